// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding and the default widths.
package pipe_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DEF_CNT_W = 32;
    localparam int SHADOW_W  = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SHADOW   = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_det.sv
// Combinational load-use detector: the load in E writes a register
// that the instruction in D is about to read.
module load_use_det
    import pipe_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 use_rs1,
    input  logic                 use_rs2,
    input  logic                 mem_read,
    output logic                 hazard
);

    // x0 is hardwired to zero, so a load targeting it never creates a hazard
    always_comb begin
        hazard = mem_read && (rd != '0) &&
                 ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and freezes a five-stage
// pipeline and counts stall cycles and accepted redirects.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int BR_SHADOW = 1,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_d,
    input  logic [REG_IDX_W-1:0] rs2_d,
    input  logic                 use_rs1_d,
    input  logic                 use_rs2_d,
    input  logic [REG_IDX_W-1:0] rd_e,
    input  logic                 mem_read_e,
    input  logic                 redirect_e,
    input  logic                 imem_valid,
    input  logic                 dmem_req_m,
    input  logic                 dmem_ack,
    output logic                 pc_we,
    output logic                 we_f2d,
    output logic                 we_d2e,
    output logic                 we_e2m,
    output logic                 we_m2w,
    output logic                 flush_f2d,
    output logic                 flush_d2e,
    output logic [1:0]           state_o,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam logic [SHADOW_W-1:0] SHADOW_INIT = SHADOW_W'(BR_SHADOW);

    hz_state_t           state;
    hz_state_t           state_next;
    logic [SHADOW_W-1:0] shadow_cnt;
    logic [SHADOW_W-1:0] shadow_next;
    logic [SHADOW_W-1:0] shadow_dec;
    logic                load_use;
    logic                frozen;
    logic                redirect_accept;

    load_use_det u_load_use_det (
        .rs1      (rs1_d),
        .rs2      (rs2_d),
        .rd       (rd_e),
        .use_rs1  (use_rs1_d),
        .use_rs2  (use_rs2_d),
        .mem_read (mem_read_e),
        .hazard   (load_use)
    );

    always_comb begin
        frozen          = dmem_req_m && !dmem_ack;
        redirect_accept = redirect_e && !frozen;
        shadow_dec      = (shadow_cnt != '0) ? (shadow_cnt - SHADOW_W'(1)) : '0;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            shadow_cnt <= '0;
        end else begin
            state      <= state_next;
            shadow_cnt <= shadow_next;
        end
    end

    // The ack cycle out of MEM_WAIT does not consume shadow; the count is
    // only spent by non-frozen cycles actually spent in SHADOW.
    always_comb begin
        state_next  = state;
        shadow_next = shadow_cnt;
        if (frozen) begin
            state_next = MEM_WAIT;
        end else if (redirect_e) begin
            shadow_next = SHADOW_INIT;
            state_next  = (BR_SHADOW > 0) ? SHADOW : RUN;
        end else begin
            case (state)
                SHADOW: begin
                    shadow_next = shadow_dec;
                    state_next  = (shadow_dec != '0) ? SHADOW : RUN;
                end
                MEM_WAIT: begin
                    state_next = (shadow_cnt != '0) ? SHADOW : RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_comb begin
        pc_we     = 1'b1;
        we_f2d    = 1'b1;
        we_d2e    = 1'b1;
        we_e2m    = 1'b1;
        we_m2w    = 1'b1;
        flush_f2d = 1'b0;
        flush_d2e = 1'b0;
        if (rst) begin
            pc_we     = 1'b0;
            we_f2d    = 1'b0;
            we_d2e    = 1'b0;
            we_e2m    = 1'b0;
            we_m2w    = 1'b0;
            flush_f2d = 1'b1;
            flush_d2e = 1'b1;
        end else if (frozen) begin
            pc_we  = 1'b0;
            we_f2d = 1'b0;
            we_d2e = 1'b0;
            we_e2m = 1'b0;
            we_m2w = 1'b0;
        end else begin
            if (redirect_e) begin
                flush_f2d = 1'b1;
                flush_d2e = 1'b1;
            end else if (load_use) begin
                pc_we     = 1'b0;
                we_f2d    = 1'b0;
                flush_d2e = 1'b1;
            end else if (!imem_valid) begin
                pc_we     = 1'b0;
                flush_f2d = 1'b1;
            end
            if (state == SHADOW) begin
                flush_f2d = 1'b1;
            end
        end
    end

    assign state_o = state;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_we) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect_accept) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected
// responses into a queue that a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_SH   = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // {pc_we, we_f2d, we_d2e, we_e2m, we_m2w, flush_f2d, flush_d2e}
    localparam logic [6:0] C_NORM  = 7'b1111100;
    localparam logic [6:0] C_REDIR = 7'b1111111;
    localparam logic [6:0] C_LU    = 7'b0011101;
    localparam logic [6:0] C_LU_SH = 7'b0011111;
    localparam logic [6:0] C_FW    = 7'b0111110;
    localparam logic [6:0] C_SH    = 7'b1111110;
    localparam logic [6:0] C_FRZ   = 7'b0000000;
    localparam logic [6:0] C_RST   = 7'b0000011;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       use1;
        logic       use2;
        logic       mr;
        logic       redir;
        logic       imv;
        logic       req;
        logic       ack;
    } stim_t;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [1:0]  st;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_d = '0;
    logic [4:0]  rs2_d = '0;
    logic        use_rs1_d = 1'b0;
    logic        use_rs2_d = 1'b0;
    logic [4:0]  rd_e = '0;
    logic        mem_read_e = 1'b0;
    logic        redirect_e = 1'b0;
    logic        imem_valid = 1'b1;
    logic        dmem_req_m = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        pc_we;
    logic        we_f2d;
    logic        we_d2e;
    logic        we_e2m;
    logic        we_m2w;
    logic        flush_f2d;
    logic        flush_d2e;
    logic [1:0]  state_o;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    exp_t        exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_stall = '0;
    logic [31:0] exp_flush = '0;
    stim_t       s;

    pipe_hazard_ctrl #(.BR_SHADOW(1), .CNT_W(32)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .use_rs1_d  (use_rs1_d),
        .use_rs2_d  (use_rs2_d),
        .rd_e       (rd_e),
        .mem_read_e (mem_read_e),
        .redirect_e (redirect_e),
        .imem_valid (imem_valid),
        .dmem_req_m (dmem_req_m),
        .dmem_ack   (dmem_ack),
        .pc_we      (pc_we),
        .we_f2d     (we_f2d),
        .we_d2e     (we_d2e),
        .we_e2m     (we_e2m),
        .we_m2w     (we_m2w),
        .flush_f2d  (flush_f2d),
        .flush_d2e  (flush_d2e),
        .state_o    (state_o),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk_in = ~clk_in;

    function automatic stim_t idle();
        stim_t v;
        v     = '0;
        v.imv = 1'b1;
        return v;
    endfunction

    // Drive one cycle of inputs and queue the response expected for it;
    // the counter model advances from the expected enables, not the DUT.
    task automatic applyStimulus(input stim_t v, input logic [6:0] ctl,
                                 input logic [1:0] st, input string name);
        exp_t e;
        @(posedge clk_in);
        #1;
        rst        = v.rst;
        rs1_d      = v.rs1;
        rs2_d      = v.rs2;
        rd_e       = v.rd;
        use_rs1_d  = v.use1;
        use_rs2_d  = v.use2;
        mem_read_e = v.mr;
        redirect_e = v.redir;
        imem_valid = v.imv;
        dmem_req_m = v.req;
        dmem_ack   = v.ack;
        if (v.rst) begin
            exp_stall = '0;
            exp_flush = '0;
        end
        e.ctl   = ctl;
        e.st    = st;
        e.stall = exp_stall;
        e.flush = exp_flush;
        exp_q.push_back(e);
        name_q.push_back(name);
        if (!v.rst) begin
            if (!ctl[6]) exp_stall = exp_stall + 32'd1;
            if (ctl[6] && ctl[0]) exp_flush = exp_flush + 32'd1;
        end
    endtask

    task automatic checkOutput(input exp_t e, input string name);
        logic [6:0] act_ctl;
        act_ctl = {pc_we, we_f2d, we_d2e, we_e2m, we_m2w, flush_f2d, flush_d2e};
        checks++;
        if (act_ctl !== e.ctl) begin
            errors++;
            $display("[TB] FAIL %s ctl actual=%b required=%b", name, act_ctl, e.ctl);
        end
        checks++;
        if (state_o !== e.st) begin
            errors++;
            $display("[TB] FAIL %s state actual=%0d required=%0d", name, state_o, e.st);
        end
        checks++;
        if (stall_cnt !== e.stall) begin
            errors++;
            $display("[TB] FAIL %s stall_cnt actual=%0d required=%0d", name, stall_cnt, e.stall);
        end
        checks++;
        if (flush_cnt !== e.flush) begin
            errors++;
            $display("[TB] FAIL %s flush_cnt actual=%0d required=%0d", name, flush_cnt, e.flush);
        end
    endtask

    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front(), name_q.pop_front());
        end
    end

    initial begin
        s = idle(); s.rst = 1'b1;
        applyStimulus(s, C_RST, ST_RUN, "reset");
        s = idle();
        applyStimulus(s, C_NORM, ST_RUN, "normal");
        s = idle(); s.mr = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.use1 = 1'b1;
        applyStimulus(s, C_LU, ST_RUN, "load_use_rs1");
        s = idle();
        applyStimulus(s, C_NORM, ST_RUN, "after_load_use");
        s = idle(); s.mr = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.use1 = 1'b1;
        applyStimulus(s, C_NORM, ST_RUN, "rd_zero");
        s = idle(); s.mr = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7;
        applyStimulus(s, C_NORM, ST_RUN, "rs2_unused");
        s.use2 = 1'b1;
        applyStimulus(s, C_LU, ST_RUN, "load_use_rs2");
        s = idle(); s.imv = 1'b0;
        applyStimulus(s, C_FW, ST_RUN, "fetch_wait");
        s = idle(); s.redir = 1'b1;
        applyStimulus(s, C_REDIR, ST_RUN, "redirect");
        s = idle();
        applyStimulus(s, C_SH, ST_SH, "shadow");
        applyStimulus(s, C_NORM, ST_RUN, "shadow_done");

        for (int i = 0; i < 3; i++) begin
            s = idle(); s.req = 1'b1; s.redir = 1'b1;
            s.mr = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.use1 = 1'b1;
            applyStimulus(s, C_FRZ, (i == 0) ? ST_RUN : ST_WAIT, "freeze");
        end
        s.ack = 1'b1;
        applyStimulus(s, C_REDIR, ST_WAIT, "ack_redirect");
        s = idle();
        applyStimulus(s, C_SH, ST_SH, "ack_shadow");

        s = idle(); s.redir = 1'b1;
        applyStimulus(s, C_REDIR, ST_RUN, "redirect2");
        s = idle(); s.req = 1'b1;
        applyStimulus(s, C_FRZ, ST_SH, "freeze_in_shadow");
        applyStimulus(s, C_FRZ, ST_WAIT, "freeze_hold");
        s.ack = 1'b1;
        applyStimulus(s, C_NORM, ST_WAIT, "ack_no_redirect");
        s = idle();
        applyStimulus(s, C_SH, ST_SH, "resume_shadow");
        applyStimulus(s, C_NORM, ST_RUN, "resume_done");

        s = idle(); s.redir = 1'b1;
        applyStimulus(s, C_REDIR, ST_RUN, "redirect3");
        applyStimulus(s, C_REDIR, ST_SH, "redirect_in_shadow");
        s = idle();
        applyStimulus(s, C_SH, ST_SH, "reloaded_shadow");
        applyStimulus(s, C_NORM, ST_RUN, "reload_done");

        s = idle(); s.redir = 1'b1;
        applyStimulus(s, C_REDIR, ST_RUN, "redirect4");
        s = idle(); s.mr = 1'b1; s.rd = 5'd9; s.rs1 = 5'd9; s.use1 = 1'b1;
        applyStimulus(s, C_LU_SH, ST_SH, "load_use_in_shadow");
        s = idle();
        applyStimulus(s, C_NORM, ST_RUN, "after_shadow_lu");

        s = idle(); s.req = 1'b1;
        applyStimulus(s, C_FRZ, ST_RUN, "freeze_pre_reset");
        applyStimulus(s, C_FRZ, ST_WAIT, "wait_pre_reset");
        s.rst = 1'b1;
        applyStimulus(s, C_RST, ST_RUN, "reset_mid_wait");
        s = idle(); s.imv = 1'b0;
        applyStimulus(s, C_FW, ST_RUN, "fetch_after_reset");
        s = idle();
        applyStimulus(s, C_NORM, ST_RUN, "final");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk_in);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain pending actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter BR_SHADOW, default 1, extra cycles flush_f2d stays high after a redirect (0..7).
REQ-002 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-003 SHALL use one clock, clk_in, and an asynchronous active-high reset, rst.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk_in  in  1  clock
- rst  in  1  async active-high reset
- rs1_d, rs2_d  in  5  source registers of the instruction in D
- use_rs1_d, use_rs2_d  in  1  D instruction reads rs1/rs2
- rd_e  in  5  destination register of the instruction in E
- mem_read_e  in  1  E instruction is a load
- redirect_e  in  1  E resolved a taken branch/jump; PC target valid
- imem_valid  in  1  fetch data valid this cycle
- dmem_req_m  in  1  M instruction has an outstanding data access
- dmem_ack  in  1  data memory completes the M access this cycle
- pc_we  out  1  PC register update enable
- we_f2d, we_d2e, we_e2m, we_m2w  out  1  pipeline register write enables
- flush_f2d, flush_d2e  out  1  load NOP into D / E (flush overrides we)
- state_o  out  2  RUN=0, SHADOW=1, MEM_WAIT=2
- stall_cnt, flush_cnt  out  CNT_W  performance counters

Function
REQ-005 SHALL evaluate outputs combinationally from inputs and registered state each cycle, with this priority: freeze > redirect > load-use > fetch-wait > normal.
REQ-006 Freeze (dmem_req_m=1 and dmem_ack=0): all we and pc_we SHALL be 0, flushes 0, redirect_e and load-use ignored; next state MEM_WAIT.
REQ-007 In MEM_WAIT, the cycle with dmem_ack=1 SHALL be evaluated as non-frozen; next state SHADOW if shadow count is nonzero, else RUN.
REQ-008 Redirect (redirect_e=1, not frozen): pc_we=1, all we=1, flush_f2d=1, flush_d2e=1; shadow count loaded with BR_SHADOW; next state SHADOW if BR_SHADOW>0, else RUN.
REQ-009 Load-use is mem_read_e and rd_e!=0 and ((use_rs1_d and rs1_d==rd_e) or (use_rs2_d and rs2_d==rd_e)).
REQ-010 Load-use (no freeze, no redirect): pc_we=0, we_f2d=0, flush_d2e=1, we_d2e=we_e2m=we_m2w=1; lasts exactly one cycle because the load advances.
REQ-011 Fetch-wait (imem_valid=0, none of the above): pc_we=0, flush_f2d=1, all we=1.
REQ-012 Normal: pc_we and all we =1, flushes 0.
REQ-013 In SHADOW, flush_f2d SHALL be forced to 1 in every non-frozen cycle; shadow count decrements per non-frozen cycle; at 0 state returns to RUN.
REQ-014 Frozen cycles SHALL hold the shadow count.
REQ-015 A redirect in SHADOW SHALL reload the shadow count to BR_SHADOW.
REQ-016 stall_cnt SHALL increment in each post-reset cycle with pc_we=0; flush_cnt SHALL increment per accepted redirect; both wrap modulo 2^CNT_W.

Reset
REQ-017 On rst assertion, state SHALL be RUN, shadow count 0, and both counters 0 immediately (asynchronous).
REQ-018 While rst=1, outputs SHALL be pc_we=0, all we=0, flush_f2d=1, flush_d2e=1, state_o=0.
REQ-019 Mid-freeze or mid-shadow reset SHALL discard pending state; the first cycle after release SHALL be evaluated from RUN.

Structure
REQ-020 Package pipe_pkg SHALL hold the state enum (RUN/SHADOW/MEM_WAIT), the default CNT_W, and the register-index width (5).
REQ-021 Load-use compare SHALL be a combinational sub-module, load_use_det.
REQ-022 Implementation SHALL be 120-400 lines of RTL, including the FSM, shadow counter and perf counters.

Verification
REQ-023 Load-use: mem_read_e=1, rd_e=5, rs1_d=5, use_rs1_d=1 for one cycle -> pc_we=0, we_f2d=0, flush_d2e=1 for that cycle only; stall_cnt +1.
REQ-024 rd_e=0 with matching rs1_d=0 and mem_read_e=1 -> no stall; all we=1.
REQ-025 Redirect with BR_SHADOW=1 -> flush_f2d=1 for 2 cycles, flush_d2e=1 for 1 cycle, pc_we=1; flush_cnt=1; state_o sequence 1 then 0.
REQ-026 dmem_req_m=1, dmem_ack=0 for 3 cycles, with redirect_e and load-use also asserted -> all enables 0 for 3 cycles, state_o=2; the ack cycle applies the redirect.
REQ-027 Freeze entered during SHADOW -> after ack, state_o=1 and flush_f2d continues for the remaining shadow count.
REQ-028 rst pulsed mid-MEM_WAIT -> state_o=0 and counters 0 asynchronously; imem_valid=0 after release gives pc_we=0, flush_f2d=1.
